regfile_read_arbiter: RTL and testbench

- Shares the register file's single read-request interface (two operand read ports, one tag) among NUM_REQ issue-side requesters, e.g. RS slots, LSB and branch unit.
- Round-robin grant; one transfer per cycle; fully pipelined.
- Routes the 1-cycle-later RF read data back to the granting requester.
- Sits between commit (ROB) and the RF write port: blocks writes to x0 and forwards a same-cycle write onto a read that would otherwise return stale data.

---
 rtl/regfile_read_arbiter_if.sv | 58 +++++
 rtl/regfile_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_read_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Bus bundle for regfile_read_arbiter: requester side, RF read/write side and response side.
// The arbiter uses the slave modport; the environment (requesters, RF, ROB) uses master.
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int RS_WIDTH = 2
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_rs1_en;
    logic [NUM_REQ-1:0]          req_rs2_en;
    logic [5*NUM_REQ-1:0]        req_rs1;
    logic [5*NUM_REQ-1:0]        req_rs2;
    logic [RS_WIDTH*NUM_REQ-1:0] req_tag;
    logic [NUM_REQ-1:0]          req_grant;

    logic                        rf_rs1_flag;
    logic                        rf_rs2_flag;
    logic [4:0]                  rf_rs1;
    logic [4:0]                  rf_rs2;
    logic [RS_WIDTH-1:0]         rf_index;
    logic                        rf_rs1_flag_in;
    logic                        rf_rs2_flag_in;
    logic [31:0]                 rf_rs1_data;
    logic [31:0]                 rf_rs2_data;

    logic                        rob_wen;
    logic [4:0]                  rob_rd;
    logic [31:0]                 rob_wdata;
    logic                        rf_wen;
    logic [4:0]                  rf_rd;
    logic [31:0]                 rf_wdata;

    logic [NUM_REQ-1:0]          rsp_valid;
    logic [RS_WIDTH-1:0]         rsp_tag;
    logic                        rsp_rs1_valid;
    logic                        rsp_rs2_valid;
    logic [31:0]                 rsp_rs1;
    logic [31:0]                 rsp_rs2;

    modport slave (
        input  req_valid, req_rs1_en, req_rs2_en, req_rs1, req_rs2, req_tag,
        output req_grant,
        output rf_rs1_flag, rf_rs2_flag, rf_rs1, rf_rs2, rf_index,
        input  rf_rs1_flag_in, rf_rs2_flag_in, rf_rs1_data, rf_rs2_data,
        input  rob_wen, rob_rd, rob_wdata,
        output rf_wen, rf_rd, rf_wdata,
        output rsp_valid, rsp_tag, rsp_rs1_valid, rsp_rs2_valid, rsp_rs1, rsp_rs2
    );

    modport master (
        output req_valid, req_rs1_en, req_rs2_en, req_rs1, req_rs2, req_tag,
        input  req_grant,
        input  rf_rs1_flag, rf_rs2_flag, rf_rs1, rf_rs2, rf_index,
        output rf_rs1_flag_in, rf_rs2_flag_in, rf_rs1_data, rf_rs2_data,
        output rob_wen, rob_rd, rob_wdata,
        input  rf_wen, rf_rd, rf_wdata,
        input  rsp_valid, rsp_tag, rsp_rs1_valid, rsp_rs2_valid, rsp_rs1, rsp_rs2
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one RF read request among NUM_REQ requesters, with commit bypass.
// Optional macro REGFILE_ARB_PRIO0_EN gives requester 0 fixed top priority.
module regfile_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int RS_WIDTH  = 2,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    regfile_read_arbiter_if.slave bus
);

    logic [REQ_IDX_W-1:0] rr_ptr;
    logic [REQ_IDX_W-1:0] winner;
    logic [REQ_IDX_W-1:0] rr_next;
    logic                 found;
    logic                 grant_en;
    logic [4:0]           win_rs1;
    logic [4:0]           win_rs2;
    logic                 win_en1;
    logic                 win_en2;
    logic [RS_WIDTH-1:0]  win_tag;
    logic                 rob_write;

    logic                 pend_valid;
    logic [REQ_IDX_W-1:0] pend_id;
    logic [4:0]           pend_rs1;
    logic [4:0]           pend_rs2;
    logic                 pend_en1;
    logic                 pend_en2;
    logic [RS_WIDTH-1:0]  pend_tag;
    logic                 byp1;
    logic                 byp2;
    logic [31:0]          byp1_data;
    logic [31:0]          byp2_data;
    logic                 rsp_en;

    // The RF flags are not needed: response valids come from the captured enables.
    logic unused_rf_flags;
    assign unused_rf_flags = bus.rf_rs1_flag_in ^ bus.rf_rs2_flag_in;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int cand;
        cand   = 0;
        found  = 1'b0;
        winner = '0;
`ifdef REGFILE_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req_valid[REQ_IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = REQ_IDX_W'(cand);
            end
        end
    end

    assign grant_en  = found & rdy_in;
    assign win_rs1   = bus.req_rs1[5*winner +: 5];
    assign win_rs2   = bus.req_rs2[5*winner +: 5];
    assign win_en1   = bus.req_rs1_en[winner];
    assign win_en2   = bus.req_rs2_en[winner];
    assign win_tag   = bus.req_tag[RS_WIDTH*winner +: RS_WIDTH];
    assign rr_next   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + REQ_IDX_W'(1);
    assign rob_write = bus.rob_wen & (bus.rob_rd != 5'd0);

    always_comb begin
        bus.req_grant = '0;
        if (grant_en) begin
            bus.req_grant[winner] = 1'b1;
        end
    end

    assign bus.rf_rs1_flag = grant_en & win_en1;
    assign bus.rf_rs2_flag = grant_en & win_en2;
    assign bus.rf_rs1      = grant_en ? win_rs1 : 5'd0;
    assign bus.rf_rs2      = grant_en ? win_rs2 : 5'd0;
    assign bus.rf_index    = grant_en ? win_tag : '0;

    assign bus.rf_wen      = rob_write;
    assign bus.rf_rd       = bus.rob_rd;
    assign bus.rf_wdata    = bus.rob_wdata;

    // The RF reads before this cycle's commit lands, so a matching commit is captured here.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr     <= '0;
            pend_valid <= 1'b0;
            pend_id    <= '0;
            pend_rs1   <= 5'd0;
            pend_rs2   <= 5'd0;
            pend_en1   <= 1'b0;
            pend_en2   <= 1'b0;
            pend_tag   <= '0;
            byp1       <= 1'b0;
            byp2       <= 1'b0;
            byp1_data  <= 32'd0;
            byp2_data  <= 32'd0;
        end else if (rdy_in) begin
            pend_valid <= found;
            if (found) begin
`ifdef REGFILE_ARB_PRIO0_EN
                if (winner != '0) begin
                    rr_ptr <= rr_next;
                end
`else
                rr_ptr <= rr_next;
`endif
                pend_id   <= winner;
                pend_rs1  <= win_rs1;
                pend_rs2  <= win_rs2;
                pend_en1  <= win_en1;
                pend_en2  <= win_en2;
                pend_tag  <= win_tag;
                byp1      <= rob_write & (bus.rob_rd == win_rs1) & win_en1;
                byp2      <= rob_write & (bus.rob_rd == win_rs2) & win_en2;
                byp1_data <= bus.rob_wdata;
                byp2_data <= bus.rob_wdata;
            end
        end
    end

    assign rsp_en = pend_valid & rdy_in;

    always_comb begin
        bus.rsp_valid = '0;
        if (rsp_en) begin
            bus.rsp_valid[pend_id] = 1'b1;
        end
    end

    assign bus.rsp_tag       = rsp_en ? pend_tag : '0;
    assign bus.rsp_rs1_valid = rsp_en & pend_en1;
    assign bus.rsp_rs2_valid = rsp_en & pend_en2;
    assign bus.rsp_rs1       = (!rsp_en || pend_rs1 == 5'd0) ? 32'd0 :
                               (byp1 ? byp1_data : bus.rf_rs1_data);
    assign bus.rsp_rs2       = (!rsp_en || pend_rs2 == 5'd0) ? 32'd0 :
                               (byp2 ? byp2_data : bus.rf_rs2_data);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: vector table plus response scoreboard,
// with a behavioural register file behind the arbiter.
module tb_regfile_read_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int RS_WIDTH = 2;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] en1;
        logic [NUM_REQ-1:0] en2;
        logic               rdy;
        logic               wen;
        logic [4:0]         rd;
        logic [31:0]        wdata;
        logic [NUM_REQ-1:0] exp_grant;
        logic               exp_wen;
    } vec_t;

    typedef struct {
        int                  id;
        logic [RS_WIDTH-1:0] tag;
        logic                en1;
        logic                en2;
        logic [31:0]         d1;
        logic [31:0]         d2;
    } rsp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;

    always #5 clk_in = ~clk_in;

    regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .RS_WIDTH(RS_WIDTH)) bus();

    regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .RS_WIDTH(RS_WIDTH)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    logic [4:0]          rs1_of [NUM_REQ];
    logic [4:0]          rs2_of [NUM_REQ];
    logic [RS_WIDTH-1:0] tag_of [NUM_REQ];
    logic [31:0]         shadow [32];
    logic [31:0]         rf_mem [32];
    rsp_t                exp_q [$];
    vec_t                vecs [$];
    int                  compared = 0;
    int                  mismatched = 0;

    always_comb begin
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_tag = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_rs1[5*k +: 5]               = rs1_of[k];
            bus.req_rs2[5*k +: 5]               = rs2_of[k];
            bus.req_tag[RS_WIDTH*k +: RS_WIDTH] = tag_of[k];
        end
    end

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hBAD0_0000;
        if (i == 5) return 32'h0000_0011;
        return 32'h100 + 32'(i);
    endfunction

    // Register file: read-before-write, outputs frozen while rdy_in is low.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
            bus.rf_rs1_data    <= 32'd0;
            bus.rf_rs2_data    <= 32'd0;
            bus.rf_rs1_flag_in <= 1'b0;
            bus.rf_rs2_flag_in <= 1'b0;
        end else begin
            if (rdy_in) begin
                bus.rf_rs1_data    <= rf_mem[bus.rf_rs1];
                bus.rf_rs2_data    <= rf_mem[bus.rf_rs2];
                bus.rf_rs1_flag_in <= bus.rf_rs1_flag;
                bus.rf_rs2_flag_in <= bus.rf_rs2_flag;
            end
            if (bus.rf_wen) rf_mem[bus.rf_rd] <= bus.rf_wdata;
        end
    end

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] en1, input logic [3:0] en2,
                                input logic rdy, input logic wen, input logic [4:0] rd,
                                input logic [31:0] wdata, input logic [3:0] exp_grant, input logic exp_wen);
        vec_t v;
        v.valid = valid; v.en1 = en1; v.en2 = en2; v.rdy = rdy; v.wen = wen; v.rd = rd;
        v.wdata = wdata; v.exp_grant = exp_grant; v.exp_wen = exp_wen;
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input vec_t v);
        if (idx == 5'd0) return 32'd0;
        if (v.wen && v.rd == idx) return v.wdata;
        return shadow[idx];
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid  = '0;
        bus.req_rs1_en = '0;
        bus.req_rs2_en = '0;
        bus.rob_wen    = 1'b0;
        bus.rob_rd     = 5'd0;
        bus.rob_wdata  = 32'd0;
        rdy_in         = 1'b1;
    endtask

    task automatic check_output(input vec_t v);
        int   g;
        rsp_t e;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) if (v.exp_grant[k]) g = k;

        compare("req_grant", 32'(bus.req_grant), 32'(v.exp_grant));
        compare("rf_rs1_flag", 32'(bus.rf_rs1_flag), (g >= 0) ? 32'(v.en1[g]) : 32'd0);
        compare("rf_rs2_flag", 32'(bus.rf_rs2_flag), (g >= 0) ? 32'(v.en2[g]) : 32'd0);
        compare("rf_rs1", 32'(bus.rf_rs1), (g >= 0) ? 32'(rs1_of[g]) : 32'd0);
        compare("rf_rs2", 32'(bus.rf_rs2), (g >= 0) ? 32'(rs2_of[g]) : 32'd0);
        compare("rf_index", 32'(bus.rf_index), (g >= 0) ? 32'(tag_of[g]) : 32'd0);
        compare("rf_wen", 32'(bus.rf_wen), 32'(v.exp_wen));

        if (v.rdy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.id);
            compare("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            compare("rsp_rs1_valid", 32'(bus.rsp_rs1_valid), 32'(e.en1));
            compare("rsp_rs2_valid", 32'(bus.rsp_rs2_valid), 32'(e.en2));
            if (e.en1) compare("rsp_rs1", bus.rsp_rs1, e.d1);
            if (e.en2) compare("rsp_rs2", bus.rsp_rs2, e.d2);
        end else begin
            compare("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        end

        if (g >= 0) begin
            e.id  = g;
            e.tag = tag_of[g];
            e.en1 = v.en1[g];
            e.en2 = v.en2[g];
            e.d1  = exp_read(rs1_of[g], v);
            e.d2  = exp_read(rs2_of[g], v);
            exp_q.push_back(e);
        end
        if (v.wen && v.rd != 5'd0) shadow[v.rd] = v.wdata;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk_in);
        bus.req_valid  = v.valid;
        bus.req_rs1_en = v.en1;
        bus.req_rs2_en = v.en2;
        rdy_in         = v.rdy;
        bus.rob_wen    = v.wen;
        bus.rob_rd     = v.rd;
        bus.rob_wdata  = v.wdata;
        #1;
        check_output(v);
    endtask

    // Reset discards any in-flight read; check that its response never shows up.
    task automatic do_reset();
        @(negedge clk_in);
        drive_idle();
        rst_in = 1'b0;
        #1;
        compare("rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            rs1_of[k] = 5'(3 + k);
            rs2_of[k] = 5'(10 + k);
            tag_of[k] = RS_WIDTH'(k ^ 2);
        end
        drive_idle();
        #2;
        do_reset();

`ifdef REGFILE_ARB_PRIO0_EN
        vecs.push_back(mk(4'h9, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(4'h9, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(4'h9, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(4'h8, 4'hF, 4'hF, 1, 0, 0, 0, 4'h8, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0));
        foreach (vecs[i]) apply_stimulus(vecs[i]);
`else
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h2, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h4, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h8, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(4'h4, 4'h4, 4'h0, 1, 1, 5'd5, 32'hDEADBEEF, 4'h4, 1));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 5'd0, 32'h00001234, 4'h0, 0));
        vecs.push_back(mk(4'hA, 4'hF, 4'hF, 1, 0, 0, 0, 4'h8, 0));
        vecs.push_back(mk(4'hA, 4'h0, 4'h0, 1, 0, 0, 0, 4'h2, 0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h1, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 5'd6, 32'h00000066, 4'h0, 1));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h4, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h8, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0));
        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Both operands from x0: response must be zero even though the RF holds garbage there.
        rs1_of[1] = 5'd0;
        rs2_of[1] = 5'd0;
        apply_stimulus(mk(4'h2, 4'h2, 4'h2, 1, 0, 0, 0, 4'h2, 0));
        apply_stimulus(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0));
        rs1_of[1] = 5'd4;
        rs2_of[1] = 5'd11;

        // Grant, then reset before the response; arbitration restarts at requester 0.
        apply_stimulus(mk(4'h4, 4'h4, 4'h4, 1, 0, 0, 0, 4'h4, 0));
        do_reset();
        apply_stimulus(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h1, 0));
        apply_stimulus(mk(4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 4'h2, 0));
        apply_stimulus(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0));
`endif

        compare("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
